redun_carry_resolve: RTL

// - Downstream of the redundant Montgomery squarer: takes one result in redundant form (NUM_WRDS words of WRD_BITS+1 bits).
// - Walks the words LSW-first, one word per cycle, resolving the carries.
// - Emits the canonical binary value as a WRD_BITS-wide stream for the output/AXI packer.
// - Flags an overflow beyond NUM_WRDS*WRD_BITS bits.

---
 rtl/redun_carry_resolve.sv | 131 +++++++++++++
 1 files changed

// File: rtl/redun_carry_resolve.sv
// Carry resolver for a redundant-form result: walks the (WRD_BITS+1)-bit words
// LSW-first, one per cycle, and streams the canonical WRD_BITS-wide value plus an overflow flag.
module redun_carry_resolve #(
   parameter int WRD_BITS = 32,
   parameter int NUM_WRDS = 33
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]    i_dat,
   input  logic                                i_val,
   output logic                                o_rdy,
   output logic [WRD_BITS-1:0]                 o_dat,
   output logic                                o_val,
   input  logic                                i_rdy,
   output logic                                o_last,
   output logic                                o_ovf
);

   localparam int RED_BITS = WRD_BITS + 1;
   localparam int DAT_BITS = NUM_WRDS * RED_BITS;
   localparam int IDX_BITS = (NUM_WRDS > 1) ? $clog2(NUM_WRDS + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                 state_r, state_s;
   logic [DAT_BITS-1:0]    data_r, data_s;
   logic [1:0]             carry_r, carry_s;
   logic [IDX_BITS-1:0]    idx_r, idx_s;
   logic [WRD_BITS-1:0]    dat_r, dat_s;
   logic                   val_r, val_s;
   logic                   last_r, last_s;
   logic                   ovf_r, ovf_s;
   logic [WRD_BITS+1:0]    sum_s;
   logic                   is_last_s;

   // Ready is only offered from IDLE and is forced low while reset is held.
   assign o_rdy  = (state_r == ST_IDLE) && !i_rst;
   assign o_dat  = dat_r;
   assign o_val  = val_r;
   assign o_last = last_r;
   assign o_ovf  = ovf_r;

   // Next-state and datapath: the captured value is shifted down so the current word is always at the bottom.
   always_comb begin
      state_s   = state_r;
      data_s    = data_r;
      carry_s   = carry_r;
      idx_s     = idx_r;
      dat_s     = dat_r;
      val_s     = val_r;
      last_s    = last_r;
      ovf_s     = ovf_r;
      sum_s     = {1'b0, data_r[RED_BITS-1:0]} + {{WRD_BITS{1'b0}}, carry_r};
      is_last_s = (idx_r == IDX_BITS'(NUM_WRDS - 1));

      case (state_r)
         ST_IDLE: begin
            if (i_val) begin
               data_s  = i_dat;
               carry_s = 2'd0;
               idx_s   = {IDX_BITS{1'b0}};
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!val_r || i_rdy) begin
               dat_s   = sum_s[WRD_BITS-1:0];
               val_s   = 1'b1;
               last_s  = is_last_s;
               ovf_s   = is_last_s && (sum_s[WRD_BITS+1:WRD_BITS] != 2'd0);
               carry_s = sum_s[WRD_BITS+1:WRD_BITS];
               idx_s   = idx_r + IDX_BITS'(1);
               data_s  = data_r >> RED_BITS;
               if (is_last_s) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (val_r && i_rdy) begin
               val_s   = 1'b0;
               last_s  = 1'b0;
               ovf_s   = 1'b0;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            val_s   = 1'b0;
            last_s  = 1'b0;
            ovf_s   = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         data_r  <= {DAT_BITS{1'b0}};
         carry_r <= 2'd0;
         idx_r   <= {IDX_BITS{1'b0}};
         dat_r   <= {WRD_BITS{1'b0}};
         val_r   <= 1'b0;
         last_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         data_r  <= data_s;
         carry_r <= carry_s;
         idx_r   <= idx_s;
         dat_r   <= dat_s;
         val_r   <= val_s;
         last_r  <= last_s;
         ovf_r   <= ovf_s;
      end
   end

endmodule
